memory_request_controller: RTL and testbench
============================================

Name: memory_request_controller

Overview:
- Upstream front end for the SRAM SequenceGenerator.
- Accepts single-beat read/write requests from the 6809 bus side over a valid/ready handshake, then latches address and write data.
- Drives StartCycle/ReadSeq/WriteSeq/Delay/Extend into the sequencer and tracks its CE strobe to detect completion.
- Captures read data and returns a one-cycle response pulse. It also owns the SRAM address/data bus drive.

Parameters:
- ADDR_WIDTH, 16, request and SRAM address width.
- DATA_WIDTH, 8, data width.
- GAP_CYCLES, 3, cycles StartCycle is held low between sequences (min 2).
- TIMEOUT, 64, max cycles waiting on either CE edge before the cycle is aborted with an error (counter 8 bits).

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept a request.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_WIDTH  request address.
- ReqWData  in  DATA_WIDTH  write data.
- CfgDelay  in  3  sequencer delay (0-7), sampled at accept.
- HoldIn  in  1  slow-device stretch request.
- RspValid  out  1  one-cycle completion pulse.
- RspRData  out  DATA_WIDTH  read data, valid with RspValid on reads.
- RspError  out  1  timeout flag, valid with RspValid.
- StartCycle  out  1  to sequencer.
- ReadSeq  out  1  to sequencer.
- WriteSeq  out  1  to sequencer.
- Delay  out  3  to sequencer.
- Extend  out  1  to sequencer.
- SeqCE  in  1  sequencer CE, active low.
- SeqOE  in  1  sequencer OE, active low.
- MemAddr  out  ADDR_WIDTH  SRAM address.
- MemDataOut  out  DATA_WIDTH  SRAM write data.
- MemDataOE  out  1  data bus drive enable.
- MemDataIn  in  DATA_WIDTH  SRAM read data.

Behaviour:
- All outputs registered.
- Reset values: ReqReady=0, RspValid=0, RspRData=0, RspError=0, StartCycle=0, ReadSeq=0, WriteSeq=0, Delay=0, Extend=0, MemAddr=0, MemDataOut=0, MemDataOE=0.
- After reset the FSM enters RELEASE with the gap counter = GAP_CYCLES.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RELEASE.
- IDLE: ReqReady=1. On ReqValid&ReqReady:
  - latch ReqAddr→MemAddr, ReqWData→MemDataOut, ReqWrite, CfgDelay→Delay;
  - ReadSeq=!ReqWrite, WriteSeq=ReqWrite, MemDataOE=ReqWrite;
  - ReqReady→0; go to ISSUE.
- ISSUE (1 cycle): StartCycle→1, clear timeout counter, go to WAIT_LOW.
- WAIT_LOW: wait for SeqCE==0, then go to WAIT_HIGH with the timeout counter cleared.
- WAIT_HIGH:
  - Every cycle with SeqCE==0 && SeqOE==0, capture MemDataIn into the internal read register; the last capture wins.
  - On SeqCE==1: RspValid=1 for exactly one cycle; RspRData=captured value on reads, unchanged on writes; RspError=0.
  - Then StartCycle→0, ReadSeq→0, WriteSeq→0, MemDataOE→0; load gap counter; go to RELEASE.
- Timeout, in WAIT_LOW or WAIT_HIGH:
  - The counter increments only while Extend==0.
  - On reaching TIMEOUT: RspValid=1, RspError=1, RspRData unchanged; same release actions; go to RELEASE.
- RELEASE:
  - StartCycle held 0 and the gap counter decrements.
  - Go to IDLE when the counter reaches 0 AND SeqCE==1. An X on SeqCE does not satisfy the SeqCE==1 condition.
  - ReqReady rises the cycle IDLE is entered.
- Extend: registered copy of HoldIn, forced to 0 outside WAIT_LOW/WAIT_HIGH.
- Latency (Delay=d, no hold): accept→RspValid is d+8 ±1 cycles.
  - Back-to-back turnaround is ≥ GAP_CYCLES+1 cycles.
- Boundaries:
  - Requests are ignored while ReqReady=0; there is no queuing.
  - ReqValid is not required to be held after the accept.
  - Reset mid-cycle aborts with no response; the RELEASE exit condition lets the sequencer drain.
  - Simultaneous CE-high and timeout: CE-high wins (RspError=0).

Decomposition:
- Shared package (mem_pkg): FSM state encoding constants, DATA/ADDR default widths, TIMEOUT/GAP defaults.
- No sub-module needed. An optional down-counter mem_down_counter may serve both the gap and timeout counters.

Test Plan:
- Read, Delay=2, SRAM model returns 8'hA5 at 16'h1234 while OE low → MemAddr=16'h1234, ReadSeq=1 during the cycle, one RspValid pulse with RspRData=8'hA5, RspError=0, MemDataOE never 1.
- Write 8'h3C to 16'h00FF, Delay=0 → MemDataOE=1 and MemDataOut=8'h3C continuously from ISSUE until SeqCE returns high; WriteSeq=1; RspValid pulse with RspError=0.
- Two requests held valid back-to-back → second accept no earlier than GAP_CYCLES+1 cycles after the first RspValid; StartCycle observed low ≥3 cycles between them.
- Sequencer model stuck with SeqCE=1 → RspValid with RspError=1 exactly 64 cycles after WAIT_LOW entry; controller returns to IDLE afterwards.
- HoldIn=1 for 100 cycles mid-read → Extend=1, no timeout; RspValid after HoldIn drops with correct data.
- Reset asserted in WAIT_HIGH → next cycle StartCycle=0, MemDataOE=0, no RspValid; ReqReady returns only after SeqCE==1 and 3 gap cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state encoding and default sizing for the SRAM request front end.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_GAP_CYCLES = 3;
  localparam int DEF_TIMEOUT    = 64;
  localparam int CNT_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RELEASE   = 3'd4
  } mem_state_e;

  function automatic logic isWaitState(input mem_state_e s);
    return (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
  endfunction

endpackage

// File: rtl/memory_request_controller.sv
// Front end for the SRAM SequenceGenerator: accepts one request at a time,
// drives the sequencer, watches CE for completion and returns a response pulse.
module memory_request_controller
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  input  logic [2:0]            CfgDelay,
  input  logic                  HoldIn,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspRData,
  output logic                  RspError,
  output logic                  StartCycle,
  output logic                  ReadSeq,
  output logic                  WriteSeq,
  output logic [2:0]            Delay,
  output logic                  Extend,
  input  logic                  SeqCE,
  input  logic                  SeqOE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemDataOut,
  output logic                  MemDataOE,
  input  logic [DATA_WIDTH-1:0] MemDataIn
);

  mem_state_e            state_q, state_d;
  logic                  reqReady_q, reqReady_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspRData_q, rspRData_d;
  logic                  rspError_q, rspError_d;
  logic                  start_q, start_d;
  logic                  readSeq_q, readSeq_d;
  logic                  writeSeq_q, writeSeq_d;
  logic [2:0]            delay_q, delay_d;
  logic                  extend_q, extend_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memDataOut_q, memDataOut_d;
  logic                  memDataOE_q, memDataOE_d;
  logic                  isWrite_q, isWrite_d;
  logic [DATA_WIDTH-1:0] capData_q, capData_d;
  logic [CNT_WIDTH-1:0]  gapCnt_q, gapCnt_d;
  logic [CNT_WIDTH-1:0]  tmoCnt_q, tmoCnt_d;

  logic [CNT_WIDTH-1:0]  tmoNext;
  logic                  tmoHit;
  logic                  doRelease;

  // The timeout clock stands still while the slow device asks for a stretch.
  assign tmoNext = extend_q ? tmoCnt_q : (tmoCnt_q + CNT_WIDTH'(1));
  assign tmoHit  = (tmoNext == CNT_WIDTH'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    reqReady_d   = reqReady_q;
    rspValid_d   = 1'b0;
    rspRData_d   = rspRData_q;
    rspError_d   = rspError_q;
    start_d      = start_q;
    readSeq_d    = readSeq_q;
    writeSeq_d   = writeSeq_q;
    delay_d      = delay_q;
    memAddr_d    = memAddr_q;
    memDataOut_d = memDataOut_q;
    memDataOE_d  = memDataOE_q;
    isWrite_d    = isWrite_q;
    capData_d    = capData_q;
    gapCnt_d     = gapCnt_q;
    tmoCnt_d     = tmoCnt_q;
    doRelease    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        reqReady_d = 1'b1;
        if (ReqValid && reqReady_q) begin
          memAddr_d    = ReqAddr;
          memDataOut_d = ReqWData;
          isWrite_d    = ReqWrite;
          delay_d      = CfgDelay;
          readSeq_d    = !ReqWrite;
          writeSeq_d   = ReqWrite;
          memDataOE_d  = ReqWrite;
          reqReady_d   = 1'b0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        start_d  = 1'b1;
        tmoCnt_d = '0;
        state_d  = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        if (SeqCE == 1'b0) begin
          tmoCnt_d = '0;
          state_d  = ST_WAIT_HIGH;
        end else begin
          tmoCnt_d = tmoNext;
          if (tmoHit) begin
            rspValid_d = 1'b1;
            rspError_d = 1'b1;
            doRelease  = 1'b1;
          end
        end
      end

      ST_WAIT_HIGH: begin
        if ((SeqCE == 1'b0) && (SeqOE == 1'b0)) begin
          capData_d = MemDataIn;
        end
        // CE returning high is checked first so it beats a coincident timeout.
        if (SeqCE == 1'b1) begin
          rspValid_d = 1'b1;
          rspError_d = 1'b0;
          if (!isWrite_q) begin
            rspRData_d = capData_q;
          end
          doRelease = 1'b1;
        end else begin
          tmoCnt_d = tmoNext;
          if (tmoHit) begin
            rspValid_d = 1'b1;
            rspError_d = 1'b1;
            doRelease  = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        start_d = 1'b0;
        if (gapCnt_q != '0) begin
          gapCnt_d = gapCnt_q - CNT_WIDTH'(1);
        end else if (SeqCE == 1'b1) begin
          reqReady_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_RELEASE;
      end
    endcase

    if (doRelease) begin
      start_d     = 1'b0;
      readSeq_d   = 1'b0;
      writeSeq_d  = 1'b0;
      memDataOE_d = 1'b0;
      gapCnt_d    = CNT_WIDTH'(GAP_CYCLES);
      state_d     = ST_RELEASE;
    end

    extend_d = HoldIn && isWaitState(state_d);
  end

  // Reset parks the FSM in RELEASE so a sequence already in flight can drain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_RELEASE;
      reqReady_q   <= 1'b0;
      rspValid_q   <= 1'b0;
      rspRData_q   <= '0;
      rspError_q   <= 1'b0;
      start_q      <= 1'b0;
      readSeq_q    <= 1'b0;
      writeSeq_q   <= 1'b0;
      delay_q      <= '0;
      extend_q     <= 1'b0;
      memAddr_q    <= '0;
      memDataOut_q <= '0;
      memDataOE_q  <= 1'b0;
      isWrite_q    <= 1'b0;
      capData_q    <= '0;
      gapCnt_q     <= CNT_WIDTH'(GAP_CYCLES);
      tmoCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      reqReady_q   <= reqReady_d;
      rspValid_q   <= rspValid_d;
      rspRData_q   <= rspRData_d;
      rspError_q   <= rspError_d;
      start_q      <= start_d;
      readSeq_q    <= readSeq_d;
      writeSeq_q   <= writeSeq_d;
      delay_q      <= delay_d;
      extend_q     <= extend_d;
      memAddr_q    <= memAddr_d;
      memDataOut_q <= memDataOut_d;
      memDataOE_q  <= memDataOE_d;
      isWrite_q    <= isWrite_d;
      capData_q    <= capData_d;
      gapCnt_q     <= gapCnt_d;
      tmoCnt_q     <= tmoCnt_d;
    end
  end

  assign ReqReady   = reqReady_q;
  assign RspValid   = rspValid_q;
  assign RspRData   = rspRData_q;
  assign RspError   = rspError_q;
  assign StartCycle = start_q;
  assign ReadSeq    = readSeq_q;
  assign WriteSeq   = writeSeq_q;
  assign Delay      = delay_q;
  assign Extend     = extend_q;
  assign MemAddr    = memAddr_q;
  assign MemDataOut = memDataOut_q;
  assign MemDataOE  = memDataOE_q;

endmodule

// File: tb/tb_memory_request_controller.sv
// Scoreboarded bench for memory_request_controller with a behavioural
// sequencer and a small SRAM model.
module tb_memory_request_controller;

  localparam int GAP = 3;
  localparam int TMO = 64;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [15:0] ReqAddr;
  logic [7:0]  ReqWData;
  logic [2:0]  CfgDelay;
  logic        HoldIn;
  logic        RspValid;
  logic [7:0]  RspRData;
  logic        RspError;
  logic        StartCycle;
  logic        ReadSeq;
  logic        WriteSeq;
  logic [2:0]  Delay;
  logic        Extend;
  logic        SeqCE;
  logic        SeqOE;
  logic [15:0] MemAddr;
  logic [7:0]  MemDataOut;
  logic        MemDataOE;
  logic [7:0]  MemDataIn;

  memory_request_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqAddr    (ReqAddr),
    .ReqWData   (ReqWData),
    .CfgDelay   (CfgDelay),
    .HoldIn     (HoldIn),
    .RspValid   (RspValid),
    .RspRData   (RspRData),
    .RspError   (RspError),
    .StartCycle (StartCycle),
    .ReadSeq    (ReadSeq),
    .WriteSeq   (WriteSeq),
    .Delay      (Delay),
    .Extend     (Extend),
    .SeqCE      (SeqCE),
    .SeqOE      (SeqOE),
    .MemAddr    (MemAddr),
    .MemDataOut (MemDataOut),
    .MemDataOE  (MemDataOE),
    .MemDataIn  (MemDataIn)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sbQueue[$];
  logic [7:0] sram [0:255];
  logic [7:0] lastExpRData;
  int         vectorCount;
  int         missCount;
  int         cycleCnt;
  int         seqPhase;
  int         seqCnt;
  int         seqExtra;
  logic       seqStuck;
  int         lowRun;
  int         lastLowRun;
  int         waitCycles, oeCycles, readSeqCycles, writeSeqCycles, addrBadCycles, wdataBadCycles;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Sequencer + SRAM model: reacts just after each rising edge.
  initial begin
    SeqCE = 1'b1;
    SeqOE = 1'b1;
    MemDataIn = 8'h00;
    seqPhase = 0;
    seqCnt = 0;
    for (int i = 0; i < 256; i++) sram[i] = 8'(i * 7 + 3);
    sram[8'h34] = 8'hA5;
    forever begin
      @(posedge Clk);
      #1;
      case (seqPhase)
        0: begin
          SeqCE = 1'b1;
          SeqOE = 1'b1;
          if (StartCycle && !seqStuck) begin
            seqPhase = 1;
            seqCnt = 0;
            SeqCE = 1'b0;
            SeqOE = !ReadSeq;
          end
        end
        1: begin
          if (!Extend) seqCnt++;
          if (seqCnt >= int'(Delay) + 6 + seqExtra) begin
            if (WriteSeq) sram[MemAddr[7:0]] = MemDataOut;
            SeqCE = 1'b1;
            SeqOE = 1'b1;
            seqPhase = 2;
          end
        end
        default: begin
          if (!StartCycle) seqPhase = 0;
        end
      endcase
      MemDataIn = (!SeqOE) ? sram[MemAddr[7:0]] : 8'h00;
    end
  end

  always @(negedge Clk) begin
    if (StartCycle === 1'b0) begin
      lowRun++;
    end else if (lowRun != 0) begin
      lastLowRun = lowRun;
      lowRun = 0;
    end
  end

  // Scoreboard consumer.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset === 1'b0 && RspValid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("rsp_unexpected", 1, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("rsp_rdata", RspRData, e.rdata);
        checkOutput("rsp_error", RspError, e.err);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                               input logic [2:0] dly, output int accCyc);
    exp_t e;
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqWData = wd;
    CfgDelay = dly;
    for (int i = 0; i < 400 && ReqReady !== 1'b1; i++) @(negedge Clk);
    if (ReqReady !== 1'b1) begin
      checkOutput("accept_expired", 0, 1);
      ReqValid = 1'b0;
      accCyc = 0;
      return;
    end
    accCyc = cycleCnt;
    if (!wr && !seqStuck) lastExpRData = sram[addr[7:0]];
    e.rdata = lastExpRData;
    e.err   = seqStuck;
    sbQueue.push_back(e);
    @(negedge Clk);
    ReqValid = 1'b0;
  endtask

  task automatic waitForResponse(input logic [15:0] expAddr, input logic [7:0] expWData, output int rspCyc);
    waitCycles = 0; oeCycles = 0; readSeqCycles = 0; writeSeqCycles = 0;
    addrBadCycles = 0; wdataBadCycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (RspValid === 1'b1) break;
      waitCycles++;
      if (MemDataOE === 1'b1) oeCycles++;
      if (MemDataOE === 1'b1 && MemDataOut !== expWData) wdataBadCycles++;
      if (ReadSeq === 1'b1) readSeqCycles++;
      if (WriteSeq === 1'b1) writeSeqCycles++;
      if (MemAddr !== expAddr) addrBadCycles++;
      @(negedge Clk);
    end
    if (RspValid === 1'b1) begin
      rspCyc = cycleCnt;
      @(negedge Clk);
      checkOutput("rsp_one_cycle", RspValid, 0);
    end else begin
      checkOutput("rsp_wait_expired", 0, 1);
      rspCyc = 0;
    end
  endtask

  initial begin
    int acc, acc2, rsp, rsp2, lat, extendCycles, rspDuring, sinceReset, ceHighSeen, rspAfter;
    vectorCount = 0; missCount = 0; cycleCnt = 0; lowRun = 0; lastLowRun = 0;
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
    CfgDelay = '0; HoldIn = 1'b0; seqStuck = 1'b0; seqExtra = 0; lastExpRData = 8'h00;

    repeat (3) @(negedge Clk);
    checkOutput("reset_ReqReady", ReqReady, 0);
    checkOutput("reset_RspValid", RspValid, 0);
    checkOutput("reset_RspRData", RspRData, 0);
    checkOutput("reset_RspError", RspError, 0);
    checkOutput("reset_StartCycle", StartCycle, 0);
    checkOutput("reset_ReadSeq", ReadSeq, 0);
    checkOutput("reset_WriteSeq", WriteSeq, 0);
    checkOutput("reset_Delay", Delay, 0);
    checkOutput("reset_Extend", Extend, 0);
    checkOutput("reset_MemAddr", MemAddr, 0);
    checkOutput("reset_MemDataOut", MemDataOut, 0);
    checkOutput("reset_MemDataOE", MemDataOE, 0);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("gap_ReqReady_low", ReqReady, 0);

    $display("[TB] read 0x1234 delay 2");
    applyStimulus(1'b0, 16'h1234, 8'h00, 3'd2, acc);
    checkOutput("rd_Delay", Delay, 2);
    waitForResponse(16'h1234, 8'h00, rsp);
    checkOutput("rd_ReadSeq_held", readSeqCycles, waitCycles);
    checkOutput("rd_MemAddr_bad", addrBadCycles, 0);
    checkOutput("rd_MemDataOE_seen", oeCycles, 0);
    lat = rsp - acc - 1;
    checkOutput("rd_latency_ok", (lat >= 9 && lat <= 11), 1);

    $display("[TB] write 0x3C to 0x00FF delay 0");
    applyStimulus(1'b1, 16'h00FF, 8'h3C, 3'd0, acc);
    waitForResponse(16'h00FF, 8'h3C, rsp);
    checkOutput("wr_MemDataOE_held", oeCycles, waitCycles);
    checkOutput("wr_WriteSeq_held", writeSeqCycles, waitCycles);
    checkOutput("wr_MemDataOut_bad", wdataBadCycles, 0);
    checkOutput("wr_MemDataOE_after", MemDataOE, 0);
    lat = rsp - acc - 1;
    checkOutput("wr_latency_ok", (lat >= 7 && lat <= 9), 1);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b0, 16'h0010, 8'h00, 3'd1, acc);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 16'h0011; ReqWData = 8'h77; CfgDelay = 3'd1;
    waitForResponse(16'h0010, 8'h00, rsp);
    applyStimulus(1'b1, 16'h0011, 8'h77, 3'd1, acc2);
    checkOutput("b2b_turnaround_ok", (acc2 + 1 - rsp >= GAP + 1), 1);
    waitForResponse(16'h0011, 8'h77, rsp2);
    checkOutput("b2b_start_low_ok", (lastLowRun >= GAP), 1);

    $display("[TB] stuck sequencer timeout");
    seqStuck = 1'b1;
    applyStimulus(1'b0, 16'h0030, 8'h00, 3'd0, acc);
    waitForResponse(16'h0030, 8'h00, rsp);
    checkOutput("tmo_cycle", rsp - acc, 2 + TMO);
    seqStuck = 1'b0;
    for (int i = 0; i < 50 && ReqReady !== 1'b1; i++) @(negedge Clk);
    checkOutput("tmo_back_to_idle", ReqReady, 1);

    $display("[TB] hold for 100 cycles during read");
    applyStimulus(1'b0, 16'h0020, 8'h00, 3'd3, acc);
    HoldIn = 1'b1;
    extendCycles = 0; rspDuring = 0;
    repeat (100) begin
      @(negedge Clk);
      if (Extend === 1'b1) extendCycles++;
      if (RspValid === 1'b1) rspDuring++;
    end
    HoldIn = 1'b0;
    checkOutput("hold_Extend_cycles", extendCycles, 100);
    checkOutput("hold_no_rsp", rspDuring, 0);
    waitForResponse(16'h0020, 8'h00, rsp);
    checkOutput("hold_Extend_cleared", Extend, 0);

    $display("[TB] reset during WAIT_HIGH");
    seqExtra = 20;
    applyStimulus(1'b1, 16'h0042, 8'h99, 3'd0, acc);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    sbQueue.delete();
    lastExpRData = 8'h00;
    checkOutput("rst_StartCycle", StartCycle, 0);
    checkOutput("rst_MemDataOE", MemDataOE, 0);
    checkOutput("rst_RspValid", RspValid, 0);
    sinceReset = 0; ceHighSeen = 0; rspAfter = 0;
    for (int i = 0; i < 200 && ReqReady !== 1'b1; i++) begin
      if (SeqCE === 1'b1) ceHighSeen++;
      if (RspValid === 1'b1) rspAfter++;
      @(negedge Clk);
      sinceReset++;
    end
    seqExtra = 0;
    checkOutput("rst_ReqReady_back", ReqReady, 1);
    checkOutput("rst_no_rsp", rspAfter, 0);
    checkOutput("rst_ce_high_first", (ceHighSeen >= 1), 1);
    checkOutput("rst_gap_ok", (sinceReset >= GAP + 1), 1);

    $display("[TB] read back 0x00FF");
    applyStimulus(1'b0, 16'h00FF, 8'h00, 3'd1, acc);
    waitForResponse(16'h00FF, 8'h00, rsp);
    lat = rsp - acc - 1;
    checkOutput("rb_latency_ok", (lat >= 8 && lat <= 10), 1);

    repeat (3) @(negedge Clk);
    checkOutput("sb_drained", sbQueue.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
